// File: rtl/guess_input_capture.sv
`default_nettype none
// ============================================================================
// Module      : guess_input_capture
// Description : Synchronises and debounces the gameplay buttons, detects press
//               events and turns them into a one-hot guess on a valid/ack
//               handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module guess_input_capture #(
    parameter int NUM_BUTTONS     = 8,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_BUTTONS-1:0] buttons_n,
    input  logic                   guess_ack,
    output logic [NUM_BUTTONS-1:0] guess,
    output logic                   guess_valid,
    output logic [NUM_BUTTONS-1:0] pressed,
    output logic                   multi_press,
    output logic                   overrun
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_st_idle         = 2'd0;
    localparam logic [1:0] c_st_pending      = 2'd1;
    localparam logic [1:0] c_st_release_wait = 2'd2;

    logic [NUM_BUTTONS-1:0] r_sync1;
    logic [NUM_BUTTONS-1:0] r_sync2;
    logic [NUM_BUTTONS-1:0] w_s;
    logic [NUM_BUTTONS-1:0] w_db;
    logic [NUM_BUTTONS-1:0] r_db_d;
    logic [NUM_BUTTONS-1:0] w_ev;
    logic [NUM_BUTTONS-1:0] w_winner;
    logic                   w_multi;

    logic [1:0]             r_state;
    logic [NUM_BUTTONS-1:0] r_guess;
    logic                   r_valid;
    logic                   r_multi;
    logic                   r_overrun;

    // Buttons are active-low; the chain resets to "released".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= buttons_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = ~r_sync2;

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_debounce
            logic [CNT_W-1:0] r_cnt;
            logic             r_level;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                end else if (w_s[gi] == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_max) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign w_db[gi] = r_level;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_db_d <= '0;
        end else begin
            r_db_d <= w_db;
        end
    end

    // Lowest set bit wins; any other simultaneous press is discarded.
    assign w_ev     = w_db & ~r_db_d;
    assign w_winner = w_ev & (~w_ev + NUM_BUTTONS'(1));
    assign w_multi  = |(w_ev & (w_ev - NUM_BUTTONS'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_guess   <= '0;
            r_valid   <= 1'b0;
            r_multi   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_multi <= w_multi;
            if ((|w_ev) && (r_state != c_st_idle)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                c_st_idle: begin
                    if (enable && (|w_ev)) begin
                        r_guess <= w_winner;
                        r_valid <= 1'b1;
                        r_state <= c_st_pending;
                    end
                end
                c_st_pending: begin
                    // Losing enable discards the guess exactly like an ack does.
                    if (!enable || guess_ack) begin
                        r_guess <= '0;
                        r_valid <= 1'b0;
                        r_state <= c_st_release_wait;
                    end
                end
                c_st_release_wait: begin
                    if (w_db == '0) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_guess <= '0;
                    r_valid <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign guess       = r_guess;
    assign guess_valid = r_valid;
    assign pressed     = w_db;
    assign multi_press = r_multi;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_guess_input_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_guess_input_capture
// Description : Self-checking bench for guess_input_capture with a behavioural
//               reference model, directed scenarios and random button traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_guess_input_capture;

    localparam int NB = 8;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable;
    logic [NB-1:0] buttons_n;
    logic          guess_ack;
    logic [NB-1:0] guess;
    logic          guess_valid;
    logic [NB-1:0] pressed;
    logic          multi_press;
    logic          overrun;

    int n_checks = 0;
    int n_fail   = 0;

    guess_input_capture #(
        .NUM_BUTTONS    (NB),
        .DEBOUNCE_CYCLES(DB),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .buttons_n  (buttons_n),
        .guess_ack  (guess_ack),
        .guess      (guess),
        .guess_valid(guess_valid),
        .pressed    (pressed),
        .multi_press(multi_press),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Reference model: pins are seen two edges late; a level flips after DB
    // consecutive edges that all disagree with it.
    logic [NB-1:0] m_pin_q0 = '1;
    logic [NB-1:0] m_pin_q1 = '1;
    logic [NB-1:0] m_hist [DB];
    logic [NB-1:0] m_db = '0;
    logic [NB-1:0] m_db_prev = '0;
    logic [NB-1:0] m_guess = '0;
    logic          m_valid = 1'b0;
    logic          m_wait = 1'b0;
    logic          m_multi = 1'b0;
    logic          m_over = 1'b0;

    task automatic model_reset();
        m_pin_q0  = '1;
        m_pin_q1  = '1;
        for (int j = 0; j < DB; j++) m_hist[j] = '0;
        m_db      = '0;
        m_db_prev = '0;
        m_guess   = '0;
        m_valid   = 1'b0;
        m_wait    = 1'b0;
        m_multi   = 1'b0;
        m_over    = 1'b0;
    endtask

    task automatic model_step();
        logic [NB-1:0] s_now;
        logic [NB-1:0] ev;
        logic [NB-1:0] nd;
        logic          all_diff;
        s_now    = ~m_pin_q1;
        m_pin_q1 = m_pin_q0;
        m_pin_q0 = buttons_n;
        ev       = m_db & ~m_db_prev;
        if (ev != '0 && (m_valid || m_wait)) m_over = 1'b1;
        m_multi = ($countones(ev) > 1);
        if (m_valid) begin
            if (!enable || guess_ack) begin
                m_valid = 1'b0;
                m_guess = '0;
                m_wait  = 1'b1;
            end
        end else if (m_wait) begin
            if (m_db == '0) m_wait = 1'b0;
        end else if (enable && ev != '0) begin
            m_guess = '0;
            for (int i = NB - 1; i >= 0; i--) begin
                if (ev[i]) m_guess = NB'(1) << i;
            end
            m_valid = 1'b1;
        end
        for (int j = DB - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = s_now;
        nd = m_db;
        for (int i = 0; i < NB; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
                if (m_hist[j][i] == m_db[i]) all_diff = 1'b0;
            end
            if (all_diff) nd[i] = ~m_db[i];
        end
        m_db_prev = m_db;
        m_db      = nd;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("guess",       32'(guess),       32'(m_guess));
        chk("guess_valid", 32'(guess_valid), 32'(m_valid));
        chk("pressed",     32'(pressed),     32'(m_db));
        chk("multi_press", 32'(multi_press), 32'(m_multi));
        chk("overrun",     32'(overrun),     32'(m_over));
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_valid(input int maxc, output int ne);
        ne = 0;
        while (!guess_valid && ne < maxc) begin
            @(posedge clk);
            ne++;
            @(negedge clk);
        end
        chk("valid_timeout", 32'(guess_valid), 32'd1);
    endtask

    task automatic ack_pulse();
        guess_ack = 1'b1;
        tick(1);
        guess_ack = 1'b0;
    endtask

    task automatic release_all();
        buttons_n = '1;
        tick(10);
    endtask

    initial begin
        int ne;
        int hold;
        int r;
        logic [NB-1:0] pat;
        enable    = 1'b0;
        buttons_n = '1;
        guess_ack = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("rst_guess",   32'(guess),       32'd0);
        chk("rst_valid",   32'(guess_valid), 32'd0);
        chk("rst_pressed", 32'(pressed),     32'd0);
        chk("rst_overrun", 32'(overrun),     32'd0);
        tick(3);
        reset = 1'b0;
        tick(20);
        chk("idle_valid", 32'(guess_valid), 32'd0);

        // Single press: latency and hold until ack
        enable    = 1'b1;
        buttons_n = 8'hFB;
        wait_valid(20, ne);
        chk("latency", 32'(ne), 32'(DB + 3));
        chk("guess_b2", 32'(guess), 32'h04);
        tick(3);
        chk("guess_held", 32'(guess), 32'h04);
        ack_pulse();
        chk("ack_drop", 32'(guess_valid), 32'd0);
        release_all();
        buttons_n = 8'hFB;
        wait_valid(20, ne);
        chk("guess_b2_again", 32'(guess), 32'h04);
        tick(1);
        ack_pulse();
        release_all();

        // Short glitches never pass the debouncer
        repeat (4) begin
            buttons_n = 8'hDF;
            tick(3);
            buttons_n = 8'hFF;
            tick(3);
            chk("glitch_pressed5", 32'(pressed[5]), 32'd0);
        end
        chk("glitch_valid", 32'(guess_valid), 32'd0);
        buttons_n = 8'hDF;
        wait_valid(20, ne);
        chk("guess_b5", 32'(guess), 32'h20);
        tick(1);
        ack_pulse();
        release_all();

        // Simultaneous press on buttons 1 and 6
        buttons_n = 8'hBD;
        wait_valid(20, ne);
        chk("guess_multi", 32'(guess), 32'h02);
        chk("multi_hi", 32'(multi_press), 32'd1);
        chk("multi_no_ovr", 32'(overrun), 32'd0);
        tick(1);
        chk("multi_lo", 32'(multi_press), 32'd0);
        ack_pulse();
        release_all();

        // Press while a guess is pending
        buttons_n = 8'hFB;
        wait_valid(20, ne);
        tick(2);
        buttons_n = 8'hF3;
        tick(8);
        buttons_n = 8'hFB;
        tick(8);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_guess", 32'(guess), 32'h04);
        ack_pulse();
        tick(2);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        release_all();
        chk("ovr_sticky2", 32'(overrun), 32'd1);

        // Enable dropped while pending
        buttons_n = 8'hFE;
        wait_valid(20, ne);
        chk("guess_b0", 32'(guess), 32'h01);
        tick(1);
        enable = 1'b0;
        tick(1);
        chk("en_drop", 32'(guess_valid), 32'd0);
        enable = 1'b1;
        tick(15);
        chk("no_repeat", 32'(guess_valid), 32'd0);
        release_all();
        buttons_n = 8'hFE;
        wait_valid(20, ne);
        chk("guess_b0_again", 32'(guess), 32'h01);
        tick(1);
        ack_pulse();
        release_all();

        // Reset mid-debounce, button held through reset release
        buttons_n = 8'hFD;
        tick(3);
        reset = 1'b1;
        #1;
        chk("mid_rst_guess",   32'(guess),       32'd0);
        chk("mid_rst_valid",   32'(guess_valid), 32'd0);
        chk("mid_rst_pressed", 32'(pressed),     32'd0);
        chk("mid_rst_multi",   32'(multi_press), 32'd0);
        chk("mid_rst_overrun", 32'(overrun),     32'd0);
        tick(2);
        reset = 1'b0;
        wait_valid(20, ne);
        chk("post_rst_guess", 32'(guess), 32'h02);
        tick(1);
        ack_pulse();
        release_all();

        // Random traffic
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                r = int'($urandom_range(0, 9));
                if (r < 4) begin
                    pat = '0;
                end else if (r < 8) begin
                    pat = NB'(1) << $urandom_range(0, NB - 1);
                end else begin
                    pat = (NB'(1) << $urandom_range(0, NB - 1)) | (NB'(1) << $urandom_range(0, NB - 1));
                end
                buttons_n = ~pat;
                hold = int'($urandom_range(1, 12));
            end
            hold--;
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            guess_ack = ($urandom_range(0, 2) == 0);
            tick(1);
        end
        guess_ack = 1'b0;
        buttons_n = '1;
        tick(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/guess_input_capture.md
Name: guess_input_capture

Overview:
- Front end for the eight gameplay push-buttons on GPIO.
- Synchronises and debounces each button, detects press events, and arbitrates simultaneous presses to a single one-hot guess.
- Presents the guess to the game control/datapath over a valid/ack handshake. guess_valid is the board-moved strobe.
- Sits between the GPIO pins and the control FSM / CheckGuess path. It is the producer for the guess interface that those blocks consume.

Parameters:
- NUM_BUTTONS, 8: number of gameplay buttons; width of the button and guess buses.
- DEBOUNCE_CYCLES, 500000: consecutive stable clk cycles needed to accept a level change (10 ms at 50 MHz). Must be at least 2.
- CNT_W, 19: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset  in  1  asynchronous, active-high reset
- enable  in  1  high while control is in the play state; press events are ignored when low
- buttons_n  in  NUM_BUTTONS  raw GPIO buttons, active-low, asynchronous to clk
- guess_ack  in  1  consumer has taken the guess; sampled only while guess_valid=1
- guess  out  NUM_BUTTONS  one-hot held guess; all zeros when guess_valid=0
- guess_valid  out  1  guess available; held until acked
- pressed  out  NUM_BUTTONS  debounced button levels, 1 = pressed
- multi_press  out  1  one-cycle pulse when two or more press events arrive in the same cycle
- overrun  out  1  sticky; set when a press event is dropped because a guess is pending or release is awaited; cleared only by reset

Behaviour:
- Reset (async, active-high):
  - all synchroniser flops = 1 (released); debounced levels = released; counters = 0; state = IDLE.
  - guess = 0, guess_valid = 0, pressed = 0, multi_press = 0, overrun = 0.
- Synchroniser: 2-flop chain per bit on buttons_n, inverted so the internal level s[i] is 1 = pressed.
- Debounce, per button independently:
  - If s[i] == db[i], cnt[i] <= 0.
  - Otherwise cnt[i] increments. On the edge where cnt[i] == DEBOUNCE_CYCLES-1, db[i] toggles and cnt[i] <= 0.
  - A mismatch run shorter than DEBOUNCE_CYCLES resets the counter and produces no change.
  - pressed = db.
- Press event: ev[i] = db[i] & ~db_d[i], where db_d is db registered one cycle. Releases generate no event.
- Arbitration:
  - If more than one ev bit is set in a cycle, the lowest index wins and the others are discarded.
  - multi_press is registered high for exactly one cycle, in the same cycle guess_valid rises.
  - In the same situation, if the winner is itself dropped (not IDLE, or enable=0 at the arbitration edge), multi_press still pulses.
- FSM:
  - IDLE: if enable=1 and any ev, guess <= winner one-hot, guess_valid <= 1, go to PENDING.
  - PENDING: guess and guess_valid held stable. If guess_ack=1, guess_valid <= 0, guess <= 0, go to RELEASE_WAIT.
  - RELEASE_WAIT: go to IDLE on the first edge where db == 0 (all buttons released). This blocks auto-repeat and chorded follow-ups.
- enable deasserted in PENDING: guess_valid <= 0, guess <= 0, go to RELEASE_WAIT at the next edge. The guess is discarded and no overrun is flagged. Ack takes no effect in that cycle.
- enable=0 in IDLE: events are ignored silently (no overrun).
- Any ev while in PENDING or RELEASE_WAIT: overrun <= 1.
- Ack in the first valid cycle is legal. guess_valid is high for a minimum of 1 cycle.
- guess_ack while guess_valid=0 is ignored.
- Latency, for a clean press with buttons_n falling before edge 1 and enable=1 in IDLE:
  - s rises after edge 2; db rises after edge DEBOUNCE_CYCLES+2.
  - guess_valid is first high after edge DEBOUNCE_CYCLES+3.
- Counters never wrap: the maximum value reached is DEBOUNCE_CYCLES-1.
- Reset mid-operation clears everything immediately (async). A button held through reset deassertion is debounced afresh and yields a normal press event.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Reset, then hold buttons_n=8'hFF for 20 cycles -> all outputs 0, no guess_valid.
- enable=1, buttons_n=8'hFB (button 2) held -> guess_valid rises after edge 7 with guess=8'h04; guess and guess_valid stay constant until guess_ack=1 for one cycle, then drop next edge. Release -> IDLE; press button 2 again -> a second guess is produced.
- Button 5 glitches low for 3 cycles then high, repeated -> pressed[5] never sets, no guess_valid; then held low 4+ cycles -> guess=8'h20.
- Buttons 1 and 6 pressed in the same cycle -> guess=8'h02, multi_press high for exactly one cycle, overrun=0.
- Hold guess pending (no ack), then press and release button 3 -> overrun=1, guess stays 8'h(previous); after ack, overrun remains 1 until reset.
- In PENDING drop enable -> guess_valid=0 next edge. Button still held, enable reasserted -> no new guess until release and re-press. Assert reset mid-debounce -> all outputs 0 immediately.
